// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback-select stage.
//   - WB_XLEN        : default data width
//   - WB_SRC_*       : writeback source indices (ALU, load, PC+4, PC+imm, imm)
//   - wb_entry_t     : writeback entry {data, rd, we} at the default width
//   - skid_state_e   : occupancy states of the 2-entry skid buffer
//   - wb_qual_we     : write-enable qualification (x0 is never written)
package wb_pkg;

  localparam int WB_XLEN = 32;

  localparam int WB_SRC_ALU   = 0;
  localparam int WB_SRC_LOAD  = 1;
  localparam int WB_SRC_PC4   = 2;
  localparam int WB_SRC_PCIMM = 3;
  localparam int WB_SRC_IMM   = 4;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic [4:0]         rd;
    logic               we;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_HEAD  = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  // A write to x0 is architecturally discarded, so never request it.
  function automatic logic wb_qual_we(input logic rd_we, input logic [4:0] rd);
    return rd_we && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: generic 2-entry skid buffer with valid/ready handshakes.
// The head register drives the output; the skid register holds the newer
// entry while the head is stalled. Order is strictly FIFO. in_ready is a
// register, so out_ready has no combinational path to in_ready.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : upstream handshake, in_data payload
//   out_valid/out_ready    : downstream handshake, out_data (head) payload
//   skid_valid, skid_data  : newer entry, exported for forwarding lookups
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_valid,
  output logic [W-1:0] skid_data
);

  skid_state_e  state_r;
  skid_state_e  state_nxt_s;
  logic         in_ready_r;
  logic [W-1:0] head_r;
  logic [W-1:0] skid_r;
  logic         acc_s;
  logic         ret_s;
  logic         head_from_in_s;
  logic         head_from_skid_s;
  logic         skid_load_s;

  assign acc_s = in_valid && in_ready_r;
  assign ret_s = (state_r != SKID_EMPTY) && out_ready;

  // Next occupancy state and which register loads on this edge.
  always_comb begin
    state_nxt_s      = state_r;
    head_from_in_s   = 1'b0;
    head_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    case (state_r)
      SKID_EMPTY: begin
        if (acc_s) begin
          state_nxt_s    = SKID_HEAD;
          head_from_in_s = 1'b1;
        end else begin
          state_nxt_s = SKID_EMPTY;
        end
      end
      SKID_HEAD: begin
        if (acc_s && ret_s) begin
          // head leaves and is replaced by the new entry on the same edge
          state_nxt_s    = SKID_HEAD;
          head_from_in_s = 1'b1;
        end else if (acc_s) begin
          state_nxt_s = SKID_FULL;
          skid_load_s = 1'b1;
        end else if (ret_s) begin
          state_nxt_s = SKID_EMPTY;
        end else begin
          state_nxt_s = SKID_HEAD;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a retire can happen
        if (ret_s) begin
          state_nxt_s      = SKID_HEAD;
          head_from_skid_s = 1'b1;
        end else begin
          state_nxt_s = SKID_FULL;
        end
      end
      default: begin
        state_nxt_s = SKID_EMPTY;
      end
    endcase
  end

  // State, registered in_ready and payload storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SKID_EMPTY;
      in_ready_r <= 1'b1;
      head_r     <= '0;
      skid_r     <= '0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != SKID_FULL);
      if (head_from_in_s) begin
        head_r <= in_data;
      end else if (head_from_skid_s) begin
        head_r <= skid_r;
      end
      if (skid_load_s) begin
        skid_r <= in_data;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = (state_r != SKID_EMPTY);
  assign out_data   = head_r;
  assign skid_valid = (state_r == SKID_FULL);
  assign skid_data  = skid_r;

endmodule

// File: rtl/wb_select_pipe.sv
// wb_select_pipe: pipelined writeback-select stage.
// Selects one of NSRC result sources, qualifies the write enable (x0 never
// written), and buffers {data, rd, we} in a 2-entry skid buffer toward the
// register-file write port. Counts retired entries that write a register.
// Optional feature macro: WB_FWD_EN adds a forwarding lookup port for decode.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : upstream handshake (in_ready registered)
//   src_data, sel, rd, rd_we      : source bus (source i at [i*XLEN +: XLEN]),
//                                   select, destination, write request
//   out_valid/out_ready           : writeback handshake
//   wb_data, wb_rd, wb_we         : head entry; wb_we is 0 while out_valid=0
//   retire_cnt                    : retired entries with wb_we=1 (wrapping)
//   fwd_rs/fwd_hit/fwd_data       : (WB_FWD_EN) pending-write lookup
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int NSRC = 5,
  parameter int SELW = $clog2(NSRC),
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [SELW-1:0]      sel,
  input  logic [4:0]           rd,
  input  logic                 rd_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_we,
  output logic [CNTW-1:0]      retire_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]           fwd_rs,
  output logic                 fwd_hit,
  output logic [XLEN-1:0]      fwd_data
`endif
);

  localparam int EW = XLEN + 6;  // {data, rd, we}

  logic [XLEN-1:0] sel_data_s;
  int              sel_idx_s;
  logic [EW-1:0]   in_entry_s;
  logic [EW-1:0]   head_entry_s;
  logic            skid_valid_s;
  logic [EW-1:0]   skid_entry_s;
  logic [CNTW-1:0] retire_cnt_r;

  assign sel_idx_s = int'(sel);

  // Source mux; out-of-range selects yield zero.
  always_comb begin
    sel_data_s = '0;
    if (sel_idx_s < NSRC) begin
      sel_data_s = src_data[sel_idx_s*XLEN +: XLEN];
    end else begin
      sel_data_s = '0;
    end
  end

  assign in_entry_s = {sel_data_s, rd, wb_qual_we(rd_we, rd)};

  wb_skid_buf #(
    .W(EW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_entry_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (head_entry_s),
    .skid_valid (skid_valid_s),
    .skid_data  (skid_entry_s)
  );

  assign wb_data = head_entry_s[EW-1:6];
  assign wb_rd   = head_entry_s[5:1];
  assign wb_we   = out_valid && head_entry_s[0];

  // Retire counter: one step per accepted writeback that writes a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_r <= '0;
    end else if (out_valid && out_ready && wb_we) begin
      retire_cnt_r <= retire_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign retire_cnt = retire_cnt_r;

`ifdef WB_FWD_EN
  // Forwarding lookup: the newer (skid) entry wins over the head.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs == 5'd0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end else if (skid_valid_s && skid_entry_s[0] && (skid_entry_s[5:1] == fwd_rs)) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_entry_s[EW-1:6];
    end else if (out_valid && head_entry_s[0] && (head_entry_s[5:1] == fwd_rs)) begin
      fwd_hit  = 1'b1;
      fwd_data = head_entry_s[EW-1:6];
    end else begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  logic fwd_unused_s;
  assign fwd_unused_s = ^{skid_valid_s, skid_entry_s};
`endif

endmodule

// File: tb/tb_wb_select_pipe.sv
// Self-checking bench for wb_select_pipe (XLEN=32, NSRC=5, CNTW=4).
// Accepted entries are pushed to a scoreboard queue; retired entries are
// popped and compared. Occupancy, counter and forwarding are modelled too.
module tb_wb_select_pipe;
  import wb_pkg::*;

  localparam int XLEN = 32;
  localparam int NSRC = 5;
  localparam int SELW = 3;
  localparam int CNTW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [NSRC*XLEN-1:0] src_data;
  logic [SELW-1:0]      sel;
  logic [4:0]           rd;
  logic                 rd_we;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      wb_data;
  logic [4:0]           wb_rd;
  logic                 wb_we;
  logic [CNTW-1:0]      retire_cnt;
`ifdef WB_FWD_EN
  logic [4:0]           fwd_rs;
  logic                 fwd_hit;
  logic [XLEN-1:0]      fwd_data;
  logic                 m_hit;
  logic [XLEN-1:0]      m_data;
`endif

  wb_select_pipe #(.XLEN(XLEN), .NSRC(NSRC), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src_data   (src_data),
    .sel        (sel),
    .rd         (rd),
    .rd_we      (rd_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .retire_cnt (retire_cnt)
`ifdef WB_FWD_EN
    ,
    .fwd_rs     (fwd_rs),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
    int              cyc;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            e;
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  logic [CNTW-1:0] exp_cnt = '0;
  bit              mon_en = 1'b0;
  bit              lat_chk = 1'b0;
  bit              acc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_sel(input logic [SELW-1:0] s,
                                              input logic [NSRC*XLEN-1:0] src);
    int idx;
    idx = int'(s);
    if (idx < NSRC) return src[idx*XLEN +: XLEN];
    return '0;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      chk("out_valid", out_valid, sb_q.size() != 0);
      chk("in_ready", in_ready, sb_q.size() < 2);
      chk("retire_cnt", retire_cnt, exp_cnt);
      if (!out_valid) chk("we_idle", wb_we, 1'b0);
`ifdef WB_FWD_EN
      m_hit  = 1'b0;
      m_data = '0;
      if (fwd_rs != 5'd0) begin
        for (int j = 0; j < sb_q.size(); j++) begin
          if (sb_q[j].we && sb_q[j].rd == fwd_rs) begin
            m_hit  = 1'b1;
            m_data = sb_q[j].data;
          end
        end
      end
      chk("fwd_hit", fwd_hit, m_hit);
      if (m_hit) chk("fwd_data", fwd_data, m_data);
`endif
      if (rst) begin
        sb_q.delete();
        exp_cnt = '0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("underflow", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_we", wb_we, e.we);
            if (lat_chk) chk("latency", cyc - e.cyc, 1);
            if (e.we) exp_cnt = exp_cnt + 4'd1;
          end
        end
        if (in_valid && in_ready) begin
          e.data = exp_sel(sel, src_data);
          e.rd   = rd;
          e.we   = rd_we && (rd != 5'd0);
          e.cyc  = cyc;
          sb_q.push_back(e);
        end
      end
    end
  end

  // Present one entry and hold it until the stage accepts it.
  task automatic send(input logic [SELW-1:0] s, input logic [4:0] r, input logic w);
    sel      = s;
    rd       = r;
    rd_we    = w;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_alu(input logic [XLEN-1:0] v);
    src_data[WB_SRC_ALU*XLEN +: XLEN] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = '0; rd = '0; rd_we = 1'b0; out_ready = 1'b1;
`ifdef WB_FWD_EN
    fwd_rs = 5'd3;
`endif
    for (int i = 0; i < NSRC; i++) src_data[i*XLEN +: XLEN] = 32'h1000 + i;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_retire_cnt", retire_cnt, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef WB_FWD_EN
    chk("rst_fwd_hit", fwd_hit, 1'b0);
`endif
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Selection, back to back, one-cycle latency.
    lat_chk = 1'b1;
    send(3'd0, 5'd1, 1'b1);
    send(3'd1, 5'd2, 1'b1);
    send(3'd2, 5'd3, 1'b1);
    send(3'd3, 5'd4, 1'b1);
    send(3'd4, 5'd5, 1'b1);
    send(3'd7, 5'd6, 1'b1);
    idle(3);
    lat_chk = 1'b0;

    // x0 suppression, then a real write.
    send(3'd0, 5'd0, 1'b1);
    send(3'd1, 5'd5, 1'b1);
    idle(3);

    // Back-pressure: A and B accepted, C held.
    out_ready = 1'b0;
    set_alu(32'hA);
    send(3'd0, 5'd6, 1'b1);
    set_alu(32'hB);
    send(3'd0, 5'd7, 1'b1);
    set_alu(32'hC);
    sel = 3'd0; rd = 5'd8; rd_we = 1'b1; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head_held", wb_data, 32'hA);
    out_ready = 1'b1;
    send(3'd0, 5'd8, 1'b1);
    idle(4);

    // Reset while FULL, with a retire and an input pending.
    out_ready = 1'b0;
    send(3'd3, 5'd9, 1'b1);
    send(3'd4, 5'd10, 1'b1);
    out_ready = 1'b1; rst = 1'b1; in_valid = 1'b1; sel = 3'd1; rd = 5'd11;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_retire_cnt", retire_cnt, 4'd0);
    chk("mrst_wb_data", wb_data, 32'h0);
    @(posedge clk); #1;

`ifdef WB_FWD_EN
    // Forwarding: skid (newer) beats head.
    out_ready = 1'b0;
    set_alu(32'hAA);
    send(3'd0, 5'd3, 1'b1);
    set_alu(32'hBB);
    send(3'd0, 5'd3, 1'b1);
    fwd_rs = 5'd3; #1;
    chk("fwd_skid_hit", fwd_hit, 1'b1);
    chk("fwd_skid_data", fwd_data, 32'hBB);
    fwd_rs = 5'd0; #1;
    chk("fwd_x0_hit", fwd_hit, 1'b0);
    fwd_rs = 5'd3;
    out_ready = 1'b1;
    idle(4);
`endif

    // Counter wrap: 17 writing retires on a 4-bit counter.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) send(3'd2, 5'd7, 1'b1);
    idle(3);
    @(negedge clk);
    chk("cnt_wrap", retire_cnt, 4'd1);
    @(posedge clk); #1;

    // Random traffic with random back-pressure.
    acc = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        sel      = 3'($urandom_range(0, 7));
        rd       = 5'($urandom_range(0, 31));
        rd_we    = 1'($urandom_range(0, 1));
        for (int i = 0; i < NSRC; i++) src_data[i*XLEN +: XLEN] = $urandom;
`ifdef WB_FWD_EN
        fwd_rs = 5'($urandom_range(0, 7));
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(5);
    @(negedge clk);
    chk("drain_empty", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
